if_id_pair_queue: RTL
=====================

IF_ID_PAIR_QUEUE -- requirements
Module: if_id_pair_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-pair entries (power of two, 2..16).
REQ-002 Parameter NOP, default 32'h00000013, instruction word driven on empty slots.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  fetch pair valid; push request.
REQ-006 InstrF1, PCF1, PCPlus8F1  input  32 each  lane-1 fetched word, PC, PC+8.
REQ-007 InstrF2, PCF2, PCPlus8F2  input  32 each  lane-2 fetched word, PC, PC+8.
REQ-008 StallD  input  1  decode cannot accept the head pair this cycle.
REQ-009 FlushD  input  1  redirect (taken branch/jump in execute); discard all queued pairs.
REQ-010 InstrD1, PCD1, PCPlus8D1  output  32 each  lane-1 head entry to decode.
REQ-011 InstrD2, PCD2, PCPlus8D2  output  32 each  lane-2 head entry to decode.
REQ-012 ValidD  output  1  head entry holds a real pair.
REQ-013 FullF  output  1  queue full; fetch shall hold PC (drives fetch en low).
REQ-014 CountQ  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage: DEPTH-entry circular buffer, each entry the six 32-bit fields of one pair; lanes always travel together.
REQ-016 Pointers wr_ptr, rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; occupancy tracked in a counter 0..DEPTH.
REQ-017 Push = en & ~FullF & ~FlushD; writes inputs at wr_ptr, wr_ptr+1.
REQ-018 Pop = ValidD & ~StallD & ~FlushD; rd_ptr+1.
REQ-019 Push and pop same cycle: count unchanged, both pointers advance.
REQ-020 FullF = (CountQ == DEPTH), combinational from registered count; push while full is ignored even if a pop occurs that cycle.
REQ-021 ValidD = (CountQ != 0); head fields read combinationally from entry rd_ptr.
REQ-022 ValidD = 0: InstrD1 = InstrD2 = NOP, all PC/PCPlus8 outputs = 0.
REQ-023 Pop while empty is impossible (ValidD gating); StallD while empty has no effect.
REQ-024 FlushD = 1: next edge sets wr_ptr = rd_ptr = 0, count = 0; same-cycle push and pop discarded; FlushD dominates en and StallD.
REQ-025 Latency: a pair pushed into an empty queue appears on D outputs in the cycle after the push edge (one cycle, no bypass).
REQ-026 Head outputs stable while StallD = 1 and FlushD = 0, regardless of pushes.
REQ-027 Order preserved: pairs leave in push order; no reordering between lanes or pairs.

Reset
REQ-028 rst asserted: pointers 0, count 0 immediately (asynchronous), so ValidD = 0, FullF = 0, CountQ = 0, D outputs at NOP/0 values.
REQ-029 Entry storage needs no reset; outputs masked by ValidD.
REQ-030 rst deasserted mid-stream: queued pairs lost; first push after release appears as head one cycle later.

Verification
REQ-031 Reset then push pair (PCF1=0x0, PCF2=0x4, InstrF1=0x00500093) -> next cycle ValidD=1, PCD1=0x0, PCD2=0x4, InstrD1=0x00500093, CountQ=1.
REQ-032 StallD=1, en=1 for 5 cycles from empty, DEPTH=4 -> CountQ 1,2,3,4,4; FullF=1 from 4th edge; head PCD1 stays 0x0; 5th pair dropped.
REQ-033 Full queue, StallD=0, en=1 -> one pop per cycle, pushes blocked while FullF=1 and resumed after; order PCD1 0x0,0x8,0x10,0x18 then 0x20; pointer wrap correct.
REQ-034 Count=3, FlushD=1 with en=1 and StallD=0 -> next cycle CountQ=0, ValidD=0, InstrD1=InstrD2=0x00000013, PCD1=0.
REQ-035 Simultaneous push/pop at CountQ=2 -> CountQ stays 2, head advances one pair.
REQ-036 rst asserted between clock edges with CountQ=3 -> ValidD=0 and CountQ=0 before next edge.

Source files
------------

// File: rtl/if_id_pair_queue.sv
// Dual-issue IF/ID boundary: a small circular queue of fetched instruction pairs
// feeding decode, with stall back-pressure and a flush on execute redirects.
module if_id_pair_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [31:0]                InstrF1,
    input  logic [31:0]                PCF1,
    input  logic [31:0]                PCPlus8F1,
    input  logic [31:0]                InstrF2,
    input  logic [31:0]                PCF2,
    input  logic [31:0]                PCPlus8F2,
    input  logic                       StallD,
    input  logic                       FlushD,
    output logic [31:0]                InstrD1,
    output logic [31:0]                PCD1,
    output logic [31:0]                PCPlus8D1,
    output logic [31:0]                InstrD2,
    output logic [31:0]                PCD2,
    output logic [31:0]                PCPlus8D2,
    output logic                       ValidD,
    output logic                       FullF,
    output logic [$clog2(DEPTH):0]     CountQ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0] instr1_mem [DEPTH];
    logic [31:0] pc1_mem    [DEPTH];
    logic [31:0] pc8_1_mem  [DEPTH];
    logic [31:0] instr2_mem [DEPTH];
    logic [31:0] pc2_mem    [DEPTH];
    logic [31:0] pc8_2_mem  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign FullF  = (count == FULL_COUNT);
    assign ValidD = (count != '0);
    assign CountQ = count;

    // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
    assign push = en & ~FullF & ~FlushD;
    assign pop  = ValidD & ~StallD & ~FlushD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FlushD) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload needs no reset: stale entries are hidden by ValidD on the read side.
    always_ff @(posedge clk) begin
        if (push) begin
            instr1_mem[wr_ptr] <= InstrF1;
            pc1_mem[wr_ptr]    <= PCF1;
            pc8_1_mem[wr_ptr]  <= PCPlus8F1;
            instr2_mem[wr_ptr] <= InstrF2;
            pc2_mem[wr_ptr]    <= PCF2;
            pc8_2_mem[wr_ptr]  <= PCPlus8F2;
        end
    end

    always_comb begin
        InstrD1   = NOP;
        PCD1      = '0;
        PCPlus8D1 = '0;
        InstrD2   = NOP;
        PCD2      = '0;
        PCPlus8D2 = '0;
        if (ValidD) begin
            InstrD1   = instr1_mem[rd_ptr];
            PCD1      = pc1_mem[rd_ptr];
            PCPlus8D1 = pc8_1_mem[rd_ptr];
            InstrD2   = instr2_mem[rd_ptr];
            PCD2      = pc2_mem[rd_ptr];
            PCPlus8D2 = pc8_2_mem[rd_ptr];
        end
    end

endmodule
